bcd_seg_display: RTL and testbench
==================================

Name: bcd_seg_display

Overview:
- Sequential, parametrised successor to the combinational `%`/`/` digit split and `sev_seg` decode used for the mouse-coordinate readout.
- Converts CHANNELS unsigned binary values into DIGITS seven-segment digits each, using an iterative shift-add-3 (double dabble) engine shared across channels.
- Adds hex mode, leading-zero blanking, overflow indication and a sample/busy/done handshake.
- Sits between the mouse/IO registers and the board HEX displays; output bus layout matches the existing `hexDisplays` packing.

Parameters:
- WIDTH, 16, bit width of each input value (2..32).
- DIGITS, 3, displayed digits per channel (1..8).
- CHANNELS, 2, number of independent values (1..8).

Ports:
- clk  input  1  system clock (50 MHz).
- reset  input  1  asynchronous, active-low reset.
- sample  input  1  request conversion; accepted only in IDLE.
- hex_mode  input  1  0 = decimal, 1 = hexadecimal; captured with values.
- blank_lz  input  1  1 = blank leading zeros; captured with values.
- values  input  CHANNELS*WIDTH  channel c at `[c*WIDTH +: WIDTH]`.
- busy  output  1  high from the cycle after acceptance until COMMIT, inclusive.
- done  output  1  one-cycle pulse in the cycle after COMMIT.
- display  output  CHANNELS*DIGITS*7  active-low segments.
  - Digit d of channel c is at `[(c*DIGITS+d)*7 +: 7]`; d = 0 is least significant.
  - Bit 0 = segment a … bit 6 = segment g.

Behaviour:
- Reset (async, reset = 0):
  - state = IDLE; busy = 0; done = 0.
  - Every display digit = 7'h7F (all segments off).
  - Any in-flight conversion is discarded.
- IDLE:
  - On sample = 1 at a clk edge, snapshot values, hex_mode and blank_lz; channel index = 0; go to LOAD.
  - sample in any other state is ignored (no queueing).
- LOAD (1 cycle):
  - Load the binary shift register with channel[idx].
  - Clear the DIGITS*4-bit BCD register.
  - Set ovf when the channel value ≥ 10^DIGITS (decimal) or ≥ 16^DIGITS (hex); compare against constants.
  - Next state: hex_mode = 0 → SHIFT with counter = WIDTH; hex_mode = 1 → ENCODE, with the BCD register = low DIGITS*4 bits of the value.
- SHIFT (WIDTH cycles):
  - Each cycle, add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1.
  - Counter decrements; at 0 go to ENCODE.
  - BCD bits shifted beyond DIGITS*4 are discarded; ovf covers that case.
- ENCODE (1 cycle): write DIGITS 7-bit codes for channel idx into a staging register, applying these rules in priority order:
  1. ovf = 1 → every digit = 7'h3F (dash, segment g only).
  2. Otherwise, nibble n decodes per the standard table: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=18, A=08, b=03, c=27, d=21, E=06, F=0E (hex).
  3. If blank_lz = 1, every digit above the most significant nonzero nibble = 7'h7F. Digit 0 is never blanked, so value 0 shows a single "0".
  - Then idx+1 < CHANNELS → LOAD with idx+1; otherwise → COMMIT.
- COMMIT (1 cycle):
  - Staging register is copied to display (all channels update atomically).
  - Next cycle: done = 1, busy = 0, state = IDLE.
  - sample asserted during COMMIT is ignored; it is accepted only in the IDLE cycle where done is high or later.
- Latency from the accepting edge to done high:
  - Decimal: CHANNELS*(WIDTH+2)+2 cycles; defaults give 38.
  - Hex: CHANNELS*2+2 cycles; defaults give 6.
- display holds its previous value for the whole conversion; it changes only at COMMIT or reset.
- Values are unsigned; there is no sign handling.

Test Plan:
- Reset, then sample with values = {16'd479, 16'd639} (ch1 = 479, ch0 = 639), decimal, blank_lz = 0:
  - done exactly 38 cycles after the accepting edge.
  - ch0 digits 2..0 = 02, 30, 18; ch1 digits = 19, 78, 18.
  - busy high for 37 cycles.
- ch0 = 5, ch1 = 0, blank_lz = 1:
  - ch0 digits 2..0 = 7F, 7F, 12.
  - ch1 = 7F, 7F, 40.
  - With blank_lz = 0, ch1 = 40, 40, 40.
- ch0 = 1000, ch1 = 999, decimal:
  - ch0 all digits = 3F.
  - ch1 = 18, 18, 18.
- hex_mode = 1, ch0 = 16'h01AF, ch1 = 16'h1000:
  - done 6 cycles after acceptance.
  - ch0 = 79, 08, 0E.
  - ch1 all digits = 3F (overflow).
- Pulse sample again at cycle 10 of a busy conversion → ignored; only one done pulse; result reflects the first snapshot even if values change mid-run.
- Assert reset (low) at cycle 20 of a conversion:
  - Immediately busy = 0, done = 0, display all 7F.
  - After release, a fresh sample completes normally.

Source files
------------

// File: rtl/bcd_seg_display_if.sv
// rtl/bcd_seg_display_if.sv - request/result bundle between the IO registers and the segment converter
interface bcd_seg_display_if #(
   parameter int WIDTH    = 16,
   parameter int DIGITS   = 3,
   parameter int CHANNELS = 2
);
   logic                         sample;
   logic                         hex_mode;
   logic                         blank_lz;
   logic [CHANNELS*WIDTH-1:0]    values;
   logic                         busy;
   logic                         done;
   logic [CHANNELS*DIGITS*7-1:0] display;

   modport master (
      output sample, hex_mode, blank_lz, values,
      input  busy, done, display
   );

   modport slave (
      input  sample, hex_mode, blank_lz, values,
      output busy, done, display
   );
endinterface

// File: rtl/bcd_seg_display.sv
// rtl/bcd_seg_display.sv - shared double-dabble engine driving active-low seven-segment digits
module bcd_seg_display #(
   parameter int WIDTH    = 16,
   parameter int DIGITS   = 3,
   parameter int CHANNELS = 2
) (
   input logic              clk,
   input logic              reset,
   bcd_seg_display_if.slave bus
);
   localparam int BCD_W  = DIGITS * 4;
   localparam int DIG_W  = DIGITS * 7;
   localparam int DISP_W = CHANNELS * DIG_W;
   localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int CNT_W  = $clog2(WIDTH + 1);

   function automatic logic [63:0] ipow(input int base, input int exp);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < exp; i++) r = r * 64'(base);
      return r;
   endfunction

   localparam logic [63:0] DEC_LIMIT = ipow(10, DIGITS);
   localparam logic [63:0] HEX_LIMIT = ipow(16, DIGITS);

   function automatic logic [6:0] seg_decode(input logic [3:0] n);
      case (n)
         4'h0: return 7'h40;
         4'h1: return 7'h79;
         4'h2: return 7'h24;
         4'h3: return 7'h30;
         4'h4: return 7'h19;
         4'h5: return 7'h12;
         4'h6: return 7'h02;
         4'h7: return 7'h78;
         4'h8: return 7'h00;
         4'h9: return 7'h18;
         4'hA: return 7'h08;
         4'hB: return 7'h03;
         4'hC: return 7'h27;
         4'hD: return 7'h21;
         4'hE: return 7'h06;
         default: return 7'h0E;
      endcase
   endfunction

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_ENCODE, S_COMMIT} state_t;

   state_t                    state, state_nxt;
   logic [IDX_W-1:0]          idx;
   logic [CNT_W-1:0]          cnt;
   logic [WIDTH-1:0]          bin;
   logic [BCD_W-1:0]          bcd;
   logic [BCD_W-1:0]          bcd_adj;
   logic                      ovf;
   logic [CHANNELS*WIDTH-1:0] vals_r;
   logic                      hex_r;
   logic                      blank_r;
   logic [DISP_W-1:0]         staging;
   logic [DISP_W-1:0]         display_r;
   logic                      done_r;
   logic [WIDTH-1:0]          chan_val;
   logic [63:0]               chan64;
   logic [DIG_W-1:0]          enc_word;
   logic [3:0]                enc_nib;
   logic                      enc_seen;

   assign chan_val = vals_r[int'(idx)*WIDTH +: WIDTH];
   assign chan64   = 64'(chan_val);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (bus.sample) state_nxt = S_LOAD;
         S_LOAD:   state_nxt = hex_r ? S_ENCODE : S_SHIFT;
         S_SHIFT:  if (cnt == CNT_W'(1)) state_nxt = S_ENCODE;
         S_ENCODE: state_nxt = (int'(idx) == CHANNELS - 1) ? S_COMMIT : S_LOAD;
         S_COMMIT: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bcd_adj = bcd;
      for (int d = 0; d < DIGITS; d++)
         if (bcd[d*4 +: 4] >= 4'd5) bcd_adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
   end

   // Walk digits from the top so everything above the first nonzero nibble can be blanked.
   always_comb begin
      enc_word = '0;
      enc_nib  = '0;
      enc_seen = 1'b0;
      for (int d = DIGITS - 1; d >= 0; d--) begin
         enc_nib = bcd[d*4 +: 4];
         if (enc_nib != 4'd0) enc_seen = 1'b1;
         if (ovf)
            enc_word[d*7 +: 7] = 7'h3F;
         else if (blank_r && !enc_seen && d != 0)
            enc_word[d*7 +: 7] = 7'h7F;
         else
            enc_word[d*7 +: 7] = seg_decode(enc_nib);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx       <= '0;
         cnt       <= '0;
         bin       <= '0;
         bcd       <= '0;
         ovf       <= 1'b0;
         vals_r    <= '0;
         hex_r     <= 1'b0;
         blank_r   <= 1'b0;
         staging   <= '1;
         display_r <= '1;
         done_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.sample) begin
                  vals_r  <= bus.values;
                  hex_r   <= bus.hex_mode;
                  blank_r <= bus.blank_lz;
                  idx     <= '0;
               end
            end
            S_LOAD: begin
               bin <= chan_val;
               cnt <= CNT_W'(WIDTH);
               ovf <= chan64 >= (hex_r ? HEX_LIMIT : DEC_LIMIT);
               bcd <= hex_r ? chan64[BCD_W-1:0] : '0;
            end
            S_SHIFT: begin
               bcd <= {bcd_adj[BCD_W-2:0], bin[WIDTH-1]};
               bin <= bin << 1;
               cnt <= cnt - CNT_W'(1);
            end
            S_ENCODE: begin
               staging[int'(idx)*DIG_W +: DIG_W] <= enc_word;
               if (int'(idx) != CHANNELS - 1) idx <= idx + IDX_W'(1);
            end
            S_COMMIT: begin
               display_r <= staging;
               done_r    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy    = (state != S_IDLE);
   assign bus.done    = done_r;
   assign bus.display = display_r;
endmodule

// File: tb/tb_bcd_seg_display.sv
// tb/tb_bcd_seg_display.sv - randomized and directed checks of bcd_seg_display against an arithmetic model
module tb_bcd_seg_display;
   localparam int WIDTH    = 16;
   localparam int DIGITS   = 3;
   localparam int CHANNELS = 2;
   localparam int DISP_W   = CHANNELS * DIGITS * 7;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;
   logic [6:0] seg_tbl [16];

   bcd_seg_display_if #(.WIDTH(WIDTH), .DIGITS(DIGITS), .CHANNELS(CHANNELS)) bus ();

   bcd_seg_display #(.WIDTH(WIDTH), .DIGITS(DIGITS), .CHANNELS(CHANNELS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Digits come from repeated division by the radix; blanking uses the highest nonzero digit.
   function automatic logic [DISP_W-1:0] model(input logic [31:0] vals, input logic hex, input logic blank);
      logic [DISP_W-1:0] r;
      int base, v, p, msd;
      int dig [DIGITS];
      r = '1;
      base = hex ? 16 : 10;
      for (int c = 0; c < CHANNELS; c++) begin
         v = int'(vals[c*WIDTH +: WIDTH]);
         p = 1;
         for (int d = 0; d < DIGITS; d++) p = p * base;
         if (v >= p) begin
            for (int d = 0; d < DIGITS; d++) r[(c*DIGITS+d)*7 +: 7] = 7'h3F;
         end else begin
            msd = 0;
            p = 1;
            for (int d = 0; d < DIGITS; d++) begin
               dig[d] = (v / p) % base;
               if (dig[d] != 0) msd = d;
               p = p * base;
            end
            for (int d = 0; d < DIGITS; d++)
               r[(c*DIGITS+d)*7 +: 7] = (blank && d > msd) ? 7'h7F : seg_tbl[dig[d]];
         end
      end
      return r;
   endfunction

   task automatic run_conv(input logic [31:0] vals, input logic hex, input logic blank,
                           input int inject_at, input string tag);
      int lat, bcnt, extra, exp_lat;
      logic changed;
      logic [DISP_W-1:0] prev;
      exp_lat = hex ? CHANNELS*2 + 2 : CHANNELS*(WIDTH+2) + 2;
      @(negedge clk);
      bus.values   = vals;
      bus.hex_mode = hex;
      bus.blank_lz = blank;
      bus.sample   = 1'b1;
      @(posedge clk);
      #1 bus.sample = 1'b0;
      lat = 0;
      bcnt = 0;
      changed = 1'b0;
      prev = bus.display;
      do begin
         @(negedge clk);
         lat++;
         if (bus.busy) bcnt++;
         if (bus.busy && bus.display !== prev) changed = 1'b1;
         if (lat == inject_at) begin
            bus.sample = 1'b1;
            bus.values = $urandom;
            bus.hex_mode = ~hex;
         end else begin
            bus.sample = 1'b0;
         end
      end while (!bus.done && lat < 100);
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " busy_cycles"}, 64'(bcnt), 64'(exp_lat - 1));
      check({tag, " display_held"}, 64'(changed), 64'(0));
      check({tag, " display"}, 64'(bus.display), 64'(model(vals, hex, blank)));
      extra = 0;
      repeat ((inject_at > 0) ? 60 : 3) begin
         @(negedge clk);
         if (bus.done) extra++;
      end
      check({tag, " extra_done"}, 64'(extra), 64'(0));
   endtask

   initial begin
      logic [31:0] rv;
      logic [15:0] ch [2];
      seg_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h18, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};
      reset = 1'b0;
      bus.sample = 1'b0;
      bus.hex_mode = 1'b0;
      bus.blank_lz = 1'b0;
      bus.values = '0;
      repeat (2) @(negedge clk);
      check("reset busy", 64'(bus.busy), 64'(0));
      check("reset done", 64'(bus.done), 64'(0));
      check("reset display", 64'(bus.display), 64'({DISP_W{1'b1}}));
      reset = 1'b1;

      run_conv({16'd479, 16'd639}, 1'b0, 1'b0, 0, "dec_479_639");
      check("dec ch0 const", 64'(bus.display[20:0]), 64'({7'h02, 7'h30, 7'h18}));
      check("dec ch1 const", 64'(bus.display[41:21]), 64'({7'h19, 7'h78, 7'h18}));

      run_conv({16'd0, 16'd5}, 1'b0, 1'b1, 0, "blank_5_0");
      check("blank ch0 const", 64'(bus.display[20:0]), 64'({7'h7F, 7'h7F, 7'h12}));
      check("blank ch1 const", 64'(bus.display[41:21]), 64'({7'h7F, 7'h7F, 7'h40}));
      run_conv({16'd0, 16'd5}, 1'b0, 1'b0, 0, "noblank_5_0");
      check("noblank ch1 const", 64'(bus.display[41:21]), 64'({7'h40, 7'h40, 7'h40}));

      run_conv({16'd999, 16'd1000}, 1'b0, 1'b0, 0, "ovf_1000_999");
      check("ovf ch0 const", 64'(bus.display[20:0]), 64'({7'h3F, 7'h3F, 7'h3F}));
      check("ovf ch1 const", 64'(bus.display[41:21]), 64'({7'h18, 7'h18, 7'h18}));

      run_conv({16'h1000, 16'h01AF}, 1'b1, 1'b0, 0, "hex_01af_1000");
      check("hex ch0 const", 64'(bus.display[20:0]), 64'({7'h79, 7'h08, 7'h0E}));
      check("hex ch1 const", 64'(bus.display[41:21]), 64'({7'h3F, 7'h3F, 7'h3F}));

      run_conv({16'd123, 16'd456}, 1'b0, 1'b0, 10, "ignore_sample");

      @(negedge clk);
      bus.values = {16'd321, 16'd654};
      bus.hex_mode = 1'b0;
      bus.sample = 1'b1;
      @(posedge clk);
      #1 bus.sample = 1'b0;
      repeat (20) @(negedge clk);
      reset = 1'b0;
      #1;
      check("midreset busy", 64'(bus.busy), 64'(0));
      check("midreset done", 64'(bus.done), 64'(0));
      check("midreset display", 64'(bus.display), 64'({DISP_W{1'b1}}));
      @(negedge clk);
      reset = 1'b1;
      run_conv({16'd42, 16'd7}, 1'b0, 1'b1, 0, "after_reset");

      for (int i = 0; i < 16; i++) begin
         for (int c = 0; c < 2; c++) begin
            case ($urandom_range(0, 3))
               0: ch[c] = 16'($urandom_range(0, 20));
               1: ch[c] = 16'($urandom_range(0, 999));
               2: ch[c] = 16'($urandom_range(990, 4100));
               default: ch[c] = 16'($urandom);
            endcase
         end
         rv = {ch[1], ch[0]};
         run_conv(rv, 1'($urandom), 1'($urandom), 0, $sformatf("rand%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
